sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Parametrised successor to the accelerator's fixed three-client memory controller.
- Arbitrates NUM_CH DMA clients (Wishbone slave, matrix multiply, convolution, future cores) onto one single-port RAM256-style SRAM, using round-robin order.
- Returns a per-channel completion pulse and shared read data.
- Sits between the compute/Wishbone blocks and the SRAM macro in the accelerator top.

Parameters:
- NUM_CH, 3: number of requesting channels, 2..8.
- AW, 8: SRAM word-address width (KICP_SRAM_AWIDTH).
- DW, 32: data width; must be a multiple of 8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_op  in  2*NUM_CH  per channel: 01 read, 11 write, 00/10 none. Channel i uses bits [2i+1:2i].
- req_addr  in  AW*NUM_CH  per-channel word address.
- req_wdata  in  DW*NUM_CH  per-channel write data.
- req_sel  in  (DW/8)*NUM_CH  per-channel byte enables for writes.
- ack  out  NUM_CH  one-cycle done pulse for the granted channel.
- rdata  out  DW  read data; valid while any ack bit is high.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the channel currently or last served.
- sram_en  out  1  SRAM enable.
- sram_we  out  DW/8  SRAM byte write enables.
- sram_addr  out  AW  SRAM address.
- sram_di  out  DW  SRAM write data.
- sram_do  in  DW  SRAM read data; valid one clock after the enabled edge.

Behaviour:
- Reset values (asynchronous on reset_n low): all outputs 0, state IDLE, last_grant = NUM_CH-1 (so channel 0 is served first).
- All outputs are registered.

States: IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE.
- IDLE: a channel is pending if its req_op is 01 or 11. At the edge where any channel is pending, pick the winner g = first pending channel searching last_grant+1 upward, wrapping modulo NUM_CH. On that edge:
  - set grant_id = g and last_grant = g;
  - sram_en = 1;
  - sram_addr = req_addr[g];
  - sram_di = req_wdata[g];
  - sram_we = req_sel[g] for a write, 0 for a read;
  - go to ACCESS.
- ACCESS: SRAM captures at this edge. sram_en and sram_we go to 0; go to CAPTURE.
- CAPTURE: rdata <= sram_do for a read (rdata keeps its previous value for a write); ack[g] <= 1; go to DONE.
- DONE: ack <= 0; go to IDLE. req_op is not sampled here.

Timing and client handshake:
- Latency: ack is high in the 3rd cycle after the request is sampled. Peak throughput is one access per 4 cycles.
- A client must hold op, addr, wdata and sel stable until it sees ack, and drop op to 00 (or issue its next op) in the cycle after ack.
- A client may change its request only after its ack; a change before that is ignored once the channel is latched.

Boundary conditions:
- Simultaneous requests: served strictly round-robin; no channel waits more than NUM_CH grants.
- A write with sel = 0 still runs the full sequence and acks (no SRAM update).
- Op 10 is treated as none and never acked.
- Reset asserted mid-operation: return to IDLE immediately; sram_en/we drop to 0; no ack is issued for the aborted access.
- The grant_id search wraps from NUM_CH-1 to 0.

Optional Feature:
- Macro SRAM_ARB_PRIO0_EN.
- Defined: channel 0 (Wishbone) has strict priority. If channel 0 is pending in IDLE it wins regardless of last_grant. Other channels still rotate round-robin among themselves, and last_grant is updated only by non-zero grants.
- Undefined: pure round-robin over all channels as described above.

Test Plan:
- NUM_CH=3. Channel 1 writes addr 0x12, data 0xDEADBEEF, sel 1111. Then channel 1 reads 0x12 -> rdata 0xDEADBEEF with ack[1] 3 cycles after the request; sram_we=1111 for exactly one cycle.
- Byte write: channel 0 writes 0x000000AA, sel 0001, to a word holding 0x11223344, then reads it -> 0x112233AA.
- Channels 0, 1, 2 all request reads from reset and hold until acked -> ack order 0, 1, 2, with acks 4 cycles apart.
- Channels 0 and 2 continuously re-request -> grants alternate 0, 2, 0, 2. With SRAM_ARB_PRIO0_EN defined, channel 0 is granted every time it is pending.
- Drive reset_n low during ACCESS of a channel 2 write -> no ack[2], sram_en=0 immediately, busy=0. The next request after reset is served with channel 0 first.
- Op 10 on channel 1 for 20 cycles -> no sram_en, no ack, busy stays 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter of NUM_CH DMA clients onto one single-port SRAM (IDLE/ACCESS/CAPTURE/DONE).
// Optional: define SRAM_ARB_PRIO0_EN to give channel 0 strict priority over the rotating channels.

module sram_port_arbiter_lane (
  input  logic [1:0] i_op,
  output logic       o_pend,
  output logic       o_wr
);
  // 01 = read, 11 = write; 00/10 are idle encodings.
  assign o_pend = i_op[0];
  assign o_wr   = i_op[1] & i_op[0];
endmodule

module sram_port_arbiter #(
  parameter int NUM_CH = 3,
  parameter int AW     = 8,
  parameter int DW     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2*NUM_CH-1:0]        req_op,
  input  logic [AW*NUM_CH-1:0]       req_addr,
  input  logic [DW*NUM_CH-1:0]       req_wdata,
  input  logic [(DW/8)*NUM_CH-1:0]   req_sel,
  output logic [NUM_CH-1:0]          ack,
  output logic [DW-1:0]              rdata,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  output logic                       sram_en,
  output logic [DW/8-1:0]            sram_we,
  output logic [AW-1:0]              sram_addr,
  output logic [DW-1:0]              sram_di,
  input  logic [DW-1:0]              sram_do
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;

  logic [NUM_CH-1:0]          w_pend, w_wr;
  logic [NUM_CH-1:0][AW-1:0]  w_addr;
  logic [NUM_CH-1:0][DW-1:0]  w_wdata;
  logic [NUM_CH-1:0][SW-1:0]  w_sel;
  logic [7:0]                 w_pend8;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_lane
      sram_port_arbiter_lane u_lane (
        .i_op   (req_op[2*c +: 2]),
        .o_pend (w_pend[c]),
        .o_wr   (w_wr[c])
      );
      assign w_addr[c]  = req_addr[AW*c +: AW];
      assign w_wdata[c] = req_wdata[DW*c +: DW];
      assign w_sel[c]   = req_sel[SW*c +: SW];
    end
  endgenerate

  assign w_pend8 = 8'(w_pend);

  state_t            r_state, w_state_nx;
  logic [2:0]        r_last, w_last_nx;
  logic [2:0]        r_grant, w_grant_nx;
  logic              r_rd, w_rd_nx;
  logic              r_en, w_en_nx;
  logic [SW-1:0]     r_we, w_we_nx;
  logic [AW-1:0]     r_addr, w_addr_nx;
  logic [DW-1:0]     r_di, w_di_nx;
  logic [NUM_CH-1:0] r_ack, w_ack_nx;
  logic [DW-1:0]     r_rdata, w_rdata_nx;
  logic              r_busy, w_busy_nx;

  logic              w_found;
  logic [2:0]        w_win;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_wdata;
  logic [SW-1:0]     w_win_sel;
  logic              w_win_wr;

  // Winner search starts one past the last grant and wraps modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
`ifdef SRAM_ARB_PRIO0_EN
    if (w_pend8[0]) begin
      w_found = 1'b1;
    end
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_CH;
`ifdef SRAM_ARB_PRIO0_EN
      if (!w_found && idx != 0 && w_pend8[3'(idx)]) begin
`else
      if (!w_found && w_pend8[3'(idx)]) begin
`endif
        w_found = 1'b1;
        w_win   = 3'(idx);
      end
    end
  end

  always_comb begin
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_win_sel   = '0;
    w_win_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == 3'(i)) begin
        w_win_addr  = w_addr[i];
        w_win_wdata = w_wdata[i];
        w_win_sel   = w_sel[i];
        w_win_wr    = w_wr[i];
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_grant_nx = r_grant;
    w_rd_nx    = r_rd;
    w_en_nx    = r_en;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_di_nx    = r_di;
    w_ack_nx   = '0;
    w_rdata_nx = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_ACCESS;
          w_grant_nx = w_win;
`ifdef SRAM_ARB_PRIO0_EN
          if (w_win != 3'd0) w_last_nx = w_win;
`else
          w_last_nx  = w_win;
`endif
          w_rd_nx    = !w_win_wr;
          w_en_nx    = 1'b1;
          w_addr_nx  = w_win_addr;
          w_di_nx    = w_win_wdata;
          w_we_nx    = w_win_wr ? w_win_sel : '0;
        end
      end
      S_ACCESS: begin
        w_state_nx = S_CAPTURE;
        w_en_nx    = 1'b0;
        w_we_nx    = '0;
      end
      S_CAPTURE: begin
        w_state_nx = S_DONE;
        if (r_rd) w_rdata_nx = sram_do;
        for (int i = 0; i < NUM_CH; i++)
          if (r_grant == 3'(i)) w_ack_nx[i] = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_last  <= 3'(NUM_CH - 1);
      r_grant <= '0;
      r_rd    <= 1'b0;
      r_en    <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_di    <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_grant <= w_grant_nx;
      r_rd    <= w_rd_nx;
      r_en    <= w_en_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_di    <= w_di_nx;
      r_ack   <= w_ack_nx;
      r_rdata <= w_rdata_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign sram_en   = r_en;
  assign sram_we   = r_we;
  assign sram_addr = r_addr;
  assign sram_di   = r_di;
endmodule
